// File: rtl/hpdcache_cmo_issuer_if.sv
// Handshake bundle between the CMO issuer, the core, the memory-side invalidation source and the CMO handler.
interface hpdcache_cmo_issuer_if #(
  parameter int unsigned NLINE_WIDTH  = 43,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned WAYS         = 8,
  parameter int unsigned WORD_WIDTH   = 64,
  parameter int unsigned ID_WIDTH     = 4
);
    localparam int unsigned ADDR_WIDTH = NLINE_WIDTH + OFFSET_WIDTH;

    logic                   core_req_valid_i;
    logic                   core_req_ready_o;
    logic [2:0]             core_req_op_i;
    logic [ADDR_WIDTH-1:0]  core_req_addr_i;
    logic [WAYS-1:0]        core_req_ways_i;
    logic [ID_WIDTH-1:0]    core_req_id_i;

    logic                   core_rsp_valid_o;
    logic                   core_rsp_ready_i;
    logic [ID_WIDTH-1:0]    core_rsp_id_o;
    logic                   core_rsp_error_o;

    logic                   mem_inval_valid_i;
    logic                   mem_inval_ready_o;
    logic [NLINE_WIDTH-1:0] mem_inval_nline_i;

    logic                   cmo_req_valid_o;
    logic                   cmo_req_ready_i;
    logic [3:0]             cmo_req_op_o;
    logic [ADDR_WIDTH-1:0]  cmo_req_addr_o;
    logic [WORD_WIDTH-1:0]  cmo_req_wdata_o;
    logic                   cmo_mem_inval_valid_o;

    modport master (
        input  core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_ways_i, core_req_id_i,
        output core_req_ready_o,
        output core_rsp_valid_o, core_rsp_id_o, core_rsp_error_o,
        input  core_rsp_ready_i,
        input  mem_inval_valid_i, mem_inval_nline_i,
        output mem_inval_ready_o,
        output cmo_req_valid_o, cmo_req_op_o, cmo_req_addr_o, cmo_req_wdata_o, cmo_mem_inval_valid_o,
        input  cmo_req_ready_i
    );

    modport slave (
        output core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_ways_i, core_req_id_i,
        input  core_req_ready_o,
        input  core_rsp_valid_o, core_rsp_id_o, core_rsp_error_o,
        output core_rsp_ready_i,
        output mem_inval_valid_i, mem_inval_nline_i,
        input  mem_inval_ready_o,
        input  cmo_req_valid_o, cmo_req_op_o, cmo_req_addr_o, cmo_req_wdata_o, cmo_mem_inval_valid_o,
        output cmo_req_ready_i
    );
endinterface

// File: rtl/hpdcache_cmo_issuer.sv
// CMO request issuer: arbitrates memory invalidations (FIFO, strict priority) and core CMO commands onto the handler.
// Optional statistics counters enabled by defining HPDCACHE_CMO_ISSUER_STATS_EN.
module hpdcache_cmo_issuer #(
    parameter int unsigned NLINE_WIDTH      = 43,
    parameter int unsigned OFFSET_WIDTH     = 6,
    parameter int unsigned WAYS             = 8,
    parameter int unsigned WORD_WIDTH       = 64,
    parameter int unsigned INVAL_FIFO_DEPTH = 4,
    parameter int unsigned ID_WIDTH         = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    hpdcache_cmo_issuer_if.master     bus
`ifdef HPDCACHE_CMO_ISSUER_STATS_EN
    ,
    output logic [31:0]               stat_core_cmo_o,
    output logic [31:0]               stat_mem_inval_o,
    output logic [31:0]               stat_fifo_full_o
`endif
);
    localparam int unsigned ADDR_WIDTH = NLINE_WIDTH + OFFSET_WIDTH;
    localparam int unsigned PTR_W      = $clog2(INVAL_FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_e;

    function automatic logic [3:0] decode_op(input logic [2:0] op);
        logic [3:0] onehot;
        onehot = 4'b0000;
        case (op)
            3'd0:    onehot = 4'b0001;
            3'd1:    onehot = 4'b0010;
            3'd2:    onehot = 4'b0100;
            3'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    state_e                  state_q, state_d;
    logic                    req_valid_q, req_valid_d;
    logic [3:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    mem_inval_q, mem_inval_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NLINE_WIDTH-1:0]  fifo_mem_q [INVAL_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    fifo_full, fifo_empty, push, pop;
    logic [3:0]              core_op_onehot;

    assign fifo_full      = (cnt_q == CNT_W'(INVAL_FIFO_DEPTH));
    assign fifo_empty     = (cnt_q == '0);
    assign push           = bus.mem_inval_valid_i && !fifo_full;
    assign core_op_onehot = decode_op(bus.core_req_op_i);

    assign bus.core_req_ready_o      = (state_q == IDLE) && fifo_empty;
    assign bus.mem_inval_ready_o     = !fifo_full;
    assign bus.cmo_req_valid_o       = req_valid_q;
    assign bus.cmo_req_op_o          = op_q;
    assign bus.cmo_req_addr_o        = addr_q;
    assign bus.cmo_req_wdata_o       = wdata_q;
    assign bus.cmo_mem_inval_valid_o = mem_inval_q;
    assign bus.core_rsp_valid_o      = rsp_valid_q;
    assign bus.core_rsp_id_o         = rsp_id_q;
    assign bus.core_rsp_error_o      = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_inval_d = mem_inval_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // The FIFO head is only read here; it is popped once the handler takes it.
                if (!fifo_empty) begin
                    op_d        = 4'b0010;
                    addr_d      = {fifo_mem_q[rd_ptr_q], {OFFSET_WIDTH{1'b0}}};
                    wdata_d     = '0;
                    mem_inval_d = 1'b1;
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end else if (bus.core_req_valid_i) begin
                    rsp_id_d = bus.core_req_id_i;
                    if (core_op_onehot == 4'b0000) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        op_d                = core_op_onehot;
                        addr_d              = bus.core_req_addr_i;
                        wdata_d             = '0;
                        wdata_d[WAYS-1:0]   = bus.core_req_ways_i;
                        mem_inval_d         = 1'b0;
                        rsp_err_d           = 1'b0;
                        req_valid_d         = 1'b1;
                        state_d             = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.cmo_req_ready_i) begin
                    req_valid_d = 1'b0;
                    pop         = mem_inval_q;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Handler ready only returns high once it has gone idle again.
                if (bus.cmo_req_ready_i) begin
                    if (mem_inval_q) begin
                        mem_inval_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.core_rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_inval_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_inval_q <= mem_inval_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= bus.mem_inval_nline_i;
    end

`ifdef HPDCACHE_CMO_ISSUER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] stat_core_q, stat_core_d;
    logic [31:0] stat_mem_q, stat_mem_d;
    logic [31:0] stat_full_q, stat_full_d;
    logic        issue_hs;

    assign issue_hs = (state_q == ISSUE) && bus.cmo_req_ready_i;

    always_comb begin
        stat_core_d = sat_inc(stat_core_q, issue_hs && !mem_inval_q);
        stat_mem_d  = sat_inc(stat_mem_q, issue_hs && mem_inval_q);
        stat_full_d = sat_inc(stat_full_q, fifo_full);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_core_q <= '0;
            stat_mem_q  <= '0;
            stat_full_q <= '0;
        end else begin
            stat_core_q <= stat_core_d;
            stat_mem_q  <= stat_mem_d;
            stat_full_q <= stat_full_d;
        end
    end

    assign stat_core_cmo_o  = stat_core_q;
    assign stat_mem_inval_o = stat_mem_q;
    assign stat_fifo_full_o = stat_full_q;
`endif
endmodule

// File: tb/tb_hpdcache_cmo_issuer.sv
// Randomized and directed bench for hpdcache_cmo_issuer against a transaction-level reference model.
module tb_hpdcache_cmo_issuer;
  localparam int unsigned NLINE = 43;
  localparam int unsigned OFF   = 6;
  localparam int unsigned WAYS  = 8;
  localparam int unsigned WORD  = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 4;
  localparam int unsigned AW    = NLINE + OFF;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  hpdcache_cmo_issuer_if #(.NLINE_WIDTH(NLINE), .OFFSET_WIDTH(OFF), .WAYS(WAYS),
                           .WORD_WIDTH(WORD), .ID_WIDTH(IDW)) bus ();

`ifdef HPDCACHE_CMO_ISSUER_STATS_EN
  logic [31:0] stat_core, stat_mem, stat_full;
`endif

  hpdcache_cmo_issuer #(.NLINE_WIDTH(NLINE), .OFFSET_WIDTH(OFF), .WAYS(WAYS), .WORD_WIDTH(WORD),
                        .INVAL_FIFO_DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef HPDCACHE_CMO_ISSUER_STATS_EN
    ,
    .stat_core_cmo_o  (stat_core),
    .stat_mem_inval_o (stat_mem),
    .stat_fifo_full_o (stat_full)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending invalidations plus the one job the issuer is working on.
  logic [NLINE-1:0] m_fifo[$];
  bit               j_act, j_mem, j_issued, j_rsp, j_err;
  logic [3:0]       j_op;
  logic [AW-1:0]    j_addr;
  logic [63:0]      j_wdata;
  logic [IDW-1:0]   j_id;

  always @(negedge clk) begin
    bit will_push;
    if (!rst_ni) begin
      m_fifo.delete();
      j_act = 0; j_mem = 0; j_issued = 0; j_rsp = 0; j_err = 0;
      chk("rst_cmo_valid", 64'(bus.cmo_req_valid_o), 64'd0);
      chk("rst_mem_inval", 64'(bus.cmo_mem_inval_valid_o), 64'd0);
      chk("rst_rsp_valid", 64'(bus.core_rsp_valid_o), 64'd0);
      chk("rst_op", 64'(bus.cmo_req_op_o), 64'd0);
      chk("rst_addr", 64'(bus.cmo_req_addr_o), 64'd0);
      chk("rst_wdata", bus.cmo_req_wdata_o, 64'd0);
      chk("rst_rsp_id", 64'(bus.core_rsp_id_o), 64'd0);
      chk("rst_rsp_err", 64'(bus.core_rsp_error_o), 64'd0);
      chk("rst_core_ready", 64'(bus.core_req_ready_o), 64'd1);
      chk("rst_mem_ready", 64'(bus.mem_inval_ready_o), 64'd1);
    end else begin
      bit exp_v;
      exp_v = j_act && !j_issued && !j_rsp;
      chk("cmo_valid", 64'(bus.cmo_req_valid_o), 64'(exp_v));
      if (exp_v) begin
        chk("cmo_op", 64'(bus.cmo_req_op_o), 64'(j_op));
        chk("cmo_addr", 64'(bus.cmo_req_addr_o), 64'(j_addr));
        chk("cmo_wdata", bus.cmo_req_wdata_o, j_wdata);
        chk("cmo_mem_inval", 64'(bus.cmo_mem_inval_valid_o), 64'(j_mem));
      end
      chk("rsp_valid", 64'(bus.core_rsp_valid_o), 64'(j_rsp));
      if (j_rsp) begin
        chk("rsp_id", 64'(bus.core_rsp_id_o), 64'(j_id));
        chk("rsp_err", 64'(bus.core_rsp_error_o), 64'(j_err));
      end
      chk("core_ready", 64'(bus.core_req_ready_o), 64'(!j_act && m_fifo.size() == 0));
      chk("mem_ready", 64'(bus.mem_inval_ready_o), 64'(m_fifo.size() < DEPTH));

      // Advance the model across the coming rising edge.
      will_push = bus.mem_inval_valid_i && (m_fifo.size() < DEPTH);
      if (!j_act) begin
        if (m_fifo.size() > 0) begin
          j_act = 1; j_mem = 1; j_issued = 0; j_rsp = 0;
          j_op = 4'b0010;
          j_addr = AW'(m_fifo[0]) << OFF;
          j_wdata = 64'd0;
        end else if (bus.core_req_valid_i) begin
          j_act = 1; j_mem = 0; j_issued = 0;
          j_id = bus.core_req_id_i;
          if (bus.core_req_op_i > 3'd3) begin
            j_rsp = 1; j_err = 1;
          end else begin
            j_rsp = 0; j_err = 0;
            j_op = 4'(1 << bus.core_req_op_i);
            j_addr = bus.core_req_addr_i;
            j_wdata = 64'(bus.core_req_ways_i);
          end
        end
      end else if (!j_issued && !j_rsp) begin
        if (bus.cmo_req_ready_i) begin
          j_issued = 1;
          if (j_mem) void'(m_fifo.pop_front());
        end
      end else if (j_issued) begin
        if (bus.cmo_req_ready_i) begin
          j_issued = 0;
          if (j_mem) j_act = 0;
          else j_rsp = 1;
        end
      end else if (j_rsp && bus.core_rsp_ready_i) begin
        j_rsp = 0; j_act = 0;
      end
      if (will_push) m_fifo.push_back(bus.mem_inval_nline_i);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic core_cmd(input logic [2:0] op, input logic [IDW-1:0] id,
                          input logic [AW-1:0] addr, input logic [WAYS-1:0] ways);
    bus.core_req_valid_i = 1'b1;
    bus.core_req_op_i    = op;
    bus.core_req_id_i    = id;
    bus.core_req_addr_i  = addr;
    bus.core_req_ways_i  = ways;
  endtask

  function automatic logic [NLINE-1:0] rnd_nline();
    return NLINE'({$urandom(), $urandom()});
  endfunction

  initial begin
    bit got_ready;
    rst_ni = 1'b0;
    bus.core_req_valid_i  = 1'b0;
    bus.core_req_op_i     = '0;
    bus.core_req_addr_i   = '0;
    bus.core_req_ways_i   = '0;
    bus.core_req_id_i     = '0;
    bus.core_rsp_ready_i  = 1'b1;
    bus.mem_inval_valid_i = 1'b0;
    bus.mem_inval_nline_i = '0;
    bus.cmo_req_ready_i   = 1'b1;
    cyc(3);
    rst_ni = 1'b1;
    cyc(2);

    // inval_all, handler busy for one cycle after taking the request
    core_cmd(3'd3, 4'd5, AW'(49'h0_1234_5678), 8'h00);
    cyc();
    bus.core_req_valid_i = 1'b0;
    cyc();
    bus.cmo_req_ready_i = 1'b0;
    cyc();
    bus.cmo_req_ready_i = 1'b1;
    cyc(4);

    // inval_by_set with a way mask
    core_cmd(3'd2, 4'd1, AW'(49'h1240), 8'hA5);
    cyc();
    bus.core_req_valid_i = 1'b0;
    cyc(6);

    // illegal opcode, response held while the core stalls
    core_cmd(3'd6, 4'd3, '0, '0);
    cyc();
    bus.core_req_valid_i = 1'b0;
    bus.core_rsp_ready_i = 1'b0;
    cyc(4);
    bus.core_rsp_ready_i = 1'b1;
    cyc(2);

    // fill the FIFO while the handler is stalled, one push rejected
    bus.cmo_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_inval_valid_i = 1'b1;
      bus.mem_inval_nline_i = rnd_nline();
      cyc();
    end
    bus.mem_inval_valid_i = 1'b0;
    cyc(2);
    bus.cmo_req_ready_i = 1'b1;
    cyc(20);

    // core command waiting behind memory invalidations
    bus.mem_inval_valid_i = 1'b1;
    bus.mem_inval_nline_i = rnd_nline();
    cyc();
    core_cmd(3'd1, 4'd9, AW'(49'h7_0000_0040), 8'h0F);
    bus.mem_inval_nline_i = rnd_nline();
    cyc();
    bus.mem_inval_valid_i = 1'b0;
    got_ready = 1'b0;
    for (int i = 0; i < 40 && !got_ready; i++) begin
      if (bus.core_req_ready_o) got_ready = 1'b1;
      else cyc();
    end
    chk("core_accept_timeout", 64'(got_ready), 64'd1);
    cyc();
    bus.core_req_valid_i = 1'b0;
    cyc(8);

    // reset in WAIT_DONE with two invalidations queued
    core_cmd(3'd1, 4'd7, AW'(49'h4_0000_0080), 8'h00);
    cyc();
    bus.core_req_valid_i = 1'b0;
    cyc();
    bus.cmo_req_ready_i   = 1'b0;
    bus.mem_inval_valid_i = 1'b1;
    bus.mem_inval_nline_i = rnd_nline();
    cyc();
    bus.mem_inval_nline_i = rnd_nline();
    cyc();
    bus.mem_inval_valid_i = 1'b0;
    rst_ni = 1'b0;
    cyc(2);
    rst_ni = 1'b1;
    bus.cmo_req_ready_i = 1'b1;
    cyc(10);

    // randomized traffic with occasional resets
    for (int c = 0; c < 5000; c++) begin
      bus.core_req_valid_i  = ($urandom_range(0, 9) < 4);
      bus.core_req_op_i     = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      bus.core_req_id_i     = IDW'($urandom());
      bus.core_req_addr_i   = AW'({$urandom(), $urandom()});
      bus.core_req_ways_i   = WAYS'($urandom());
      bus.core_rsp_ready_i  = ($urandom_range(0, 9) < 6);
      bus.mem_inval_valid_i = ($urandom_range(0, 9) < 3);
      bus.mem_inval_nline_i = rnd_nline();
      bus.cmo_req_ready_i   = ($urandom_range(0, 9) < 6);
      rst_ni                = ($urandom_range(0, 599) != 0);
      cyc();
    end
    rst_ni = 1'b1;
    bus.core_req_valid_i  = 1'b0;
    bus.mem_inval_valid_i = 1'b0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
